// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte FIFO and CTS-gated frame starts, clocked by clk_pixel.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int unsigned BAUD_COUNT = 645,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [7:0]                        data_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  input  logic                              cts_n_in,
  output logic                              tx_out,
  output logic                              busy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(BAUD_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        cts_sync;
  logic              cts_ok;
  logic              push;
  logic              pop;
  logic              can_start;
  logic              baud_wrap;
  logic              line_c;
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign ready_out = (count_out < CNT_W'(FIFO_DEPTH));
  assign push      = valid_in && ready_out;
  assign cts_ok    = ~cts_sync[1];
  assign baud_wrap = (baud_cnt == BAUD_W'(BAUD_COUNT - 1));
  assign can_start = (count_out != '0) && cts_ok;
  assign pop       = can_start && ((state == ST_IDLE) || ((state == ST_STOP) && baud_wrap));

  // Flow-control synchronizer; resets to "not clear to send"
  always_ff @(posedge clk_in) begin
    if (rst_in) cts_sync <= 2'b11;
    else        cts_sync <= {cts_sync[0], cts_n_in};
  end

  // Storage array carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_out <= count_out + CNT_W'(1);
        2'b01:   count_out <= count_out - CNT_W'(1);
        default: count_out <= count_out;
      endcase
    end
  end

  // Line level implied by the current state; registered into tx_out one cycle later
  always_comb begin
    line_c = 1'b1;
    case (state)
      ST_START:  line_c = 1'b0;
      ST_DATA:   line_c = shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_c = parity_bit;
`endif
      default:   line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx_out     <= 1'b1;
      busy_out   <= 1'b0;
    end else begin
      tx_out   <= line_c;
      busy_out <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            baud_cnt   <= '0;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when a byte is waiting
            if (pop) begin
              shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^mem[rd_ptr];
`endif
              state      <= ST_START;
            end else begin
              state      <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_COUNT=4: frames are sampled every cycle and
// compared against hand-built line patterns; honours UART_TX_PARITY_EN like the design.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int unsigned BC    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned FL = FB * BC;

  logic          clk_in;
  logic          rst_in;
  logic [7:0]    data_in;
  logic          valid_in;
  logic          ready_out;
  logic          cts_n_in;
  logic          tx_out;
  logic          busy_out;
  logic [CW-1:0] count_out;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.BAUD_COUNT(BC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .cts_n_in  (cts_n_in),
    .tx_out    (tx_out),
    .busy_out  (busy_out),
    .count_out (count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle line: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [63:0] frame_pat(input logic [7:0] b);
    logic [63:0] v = '0;
    logic        bitv;
    for (int j = 0; j < FB; j++) begin
      if (j == 0)           bitv = 1'b0;
      else if (j <= 8)      bitv = b[j-1];
      else if (j == FB - 1) bitv = 1'b1;
      else                  bitv = ^b;
      for (int t = 0; t < BC; t++) v[j*BC + t] = bitv;
    end
    return v;
  endfunction

  task automatic push(input logic [7:0] d);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // exp_wait: falling edges until tx_out is first seen low, counted from the next one
  task automatic rx_frame(input string tag, input logic [7:0] b, input int exp_wait,
                          output logic [63:0] vec);
    int waited = 0;
    int busy_n = 0;
    vec = '0;
    do begin
      @(negedge clk_in);
      waited++;
    end while (tx_out !== 1'b0 && waited < 2000);
    check({tag, " start"}, 64'(waited), 64'(exp_wait));
    if (tx_out !== 1'b0) return;
    for (int k = 0; k < FL; k++) begin
      if (k != 0) @(negedge clk_in);
      vec[k] = tx_out;
      if (busy_out === 1'b1) busy_n++;
    end
    check({tag, " line"}, vec, frame_pat(b));
    check({tag, " busy"}, 64'(busy_n), 64'(FL));
  endtask

  initial begin
    logic [63:0] vec;
    int          bad;

    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    cts_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst tx",    64'(tx_out),    64'd1);
    check("rst busy",  64'(busy_out),  64'd0);
    check("rst count", 64'(count_out), 64'd0);
    check("rst ready", 64'(ready_out), 64'd1);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Single frame: start bit two edges after the push edge
    push(8'hA5);
    rx_frame("basic a5", 8'hA5, 2, vec);
    @(negedge clk_in);
    check("basic idle tx",   64'(tx_out),   64'd1);
    check("basic idle busy", 64'(busy_out), 64'd0);

    // Fill with CTS held off; the 17th byte must be dropped
    cts_n_in = 1'b1;
    repeat (4) @(negedge clk_in);
    for (int i = 0; i <= 16; i++) begin
      data_in  = 8'(i);
      valid_in = 1'b1;
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    check("full count", 64'(count_out), 64'd16);
    check("full ready", 64'(ready_out), 64'd0);
    repeat (10) @(negedge clk_in);
    check("holdoff tx",   64'(tx_out),   64'd1);
    check("holdoff busy", 64'(busy_out), 64'd0);
    cts_n_in = 1'b0;
    @(negedge clk_in);
    rx_frame("fifo 00", 8'h00, 3, vec);
    for (int i = 1; i < 16; i++) rx_frame("fifo seq", 8'(i), 1, vec);
    check("drain count", 64'(count_out), 64'd0);
    bad = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1) bad++;
    end
    check("dropped byte", 64'(bad), 64'd0);

    // Back-to-back: second start bit directly after the first stop bit
    push(8'hFF);
    push(8'h00);
    rx_frame("b2b ff", 8'hFF, 1, vec);
    rx_frame("b2b 00", 8'h00, 1, vec);
    @(negedge clk_in);
    check("b2b end busy", 64'(busy_out), 64'd0);

    // CTS dropped during the data bits lets the current frame finish only
    push(8'h3C);
    push(8'h55);
    fork
      rx_frame("cts 3c", 8'h3C, 1, vec);
      begin
        repeat (12) @(negedge clk_in);
        cts_n_in = 1'b1;
      end
    join
    bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1) bad++;
    end
    check("cts hold line",  64'(bad),       64'd0);
    check("cts hold count", 64'(count_out), 64'd1);
    cts_n_in = 1'b0;
    @(negedge clk_in);
    rx_frame("cts 55", 8'h55, 3, vec);
    check("cts end count", 64'(count_out), 64'd0);

`ifdef UART_TX_PARITY_EN
    push(8'hA5);
    push(8'h07);
    rx_frame("par a5", 8'hA5, 1, vec);
    check("par bit a5", 64'(vec[9*BC + 1]), 64'd0);
    rx_frame("par 07", 8'h07, 1, vec);
    check("par bit 07", 64'(vec[9*BC + 1]), 64'd1);
`endif

    // Reset in the middle of data bit 4 of 0x81 with three bytes queued
    push(8'h81);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (20) @(negedge clk_in);
    check("pre-rst bit4",  64'(tx_out),    64'd0);
    check("pre-rst busy",  64'(busy_out),  64'd1);
    check("pre-rst count", 64'(count_out), 64'd3);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid-rst tx",    64'(tx_out),    64'd1);
    check("mid-rst busy",  64'(busy_out),  64'd0);
    check("mid-rst count", 64'(count_out), 64'd0);
    check("mid-rst ready", 64'(ready_out), 64'd1);
    rst_in = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1 || busy_out !== 1'b0) bad++;
    end
    check("post-rst quiet", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
